// File: rtl/krv_bus_pkg.sv
// Shared load/store bus definitions for the KRV-32 data side: size codes,
// slave FSM states and the byte-count helper.
package krv_bus_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [31:0] DATA_OFFSET_DEF = 32'd2000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_e;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_HALF: size_to_nbytes = 3'd2;
            SZ_WORD: size_to_nbytes = 3'd4;
            default: size_to_nbytes = 3'd1;
        endcase
    endfunction
endpackage

// File: rtl/krv_dmem_io_if.sv
// Request/response handshake bundle between the load/store stage (master)
// and the data-memory/IO slave.
interface krv_dmem_io_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/krv_addr_check.sv
// Combinational decode of an absolute byte address into an array offset,
// transfer length and a fault flag (bad size, misalignment, out of range).
module krv_addr_check
    import krv_bus_pkg::*;
#(
    parameter logic [31:0] DATA_OFFSET = DATA_OFFSET_DEF,
    parameter int          DMEM_BYTES  = 32,
    parameter int          AW          = $clog2(DMEM_BYTES)
) (
    input  logic [31:0]   addr,
    input  logic [1:0]    size,
    output logic [AW-1:0] offset,
    output logic [2:0]    nbytes,
    output logic          err
);
    logic [31:0] ofs_full;
    logic [32:0] end_excl;

    // Addresses below DATA_OFFSET wrap to huge offsets and land in the range fault.
    assign ofs_full = addr - DATA_OFFSET;
    assign nbytes   = size_to_nbytes(size);
    assign end_excl = {1'b0, ofs_full} + 33'(nbytes);
    assign offset   = ofs_full[AW-1:0];

    assign err = (size == SZ_ILL)
               | ((size == SZ_HALF) & ofs_full[0])
               | ((size == SZ_WORD) & (ofs_full[1:0] != 2'b00))
               | (end_excl > 33'(DMEM_BYTES));
endmodule

// File: rtl/krv_dmem_io.sv
// Byte-serial data memory / LED slave, big-endian, one byte per clock.
// Optional KRV_CYCLE_CNT_EN maps a free-running cycle counter just past the array.
module krv_dmem_io
    import krv_bus_pkg::*;
#(
    parameter logic [31:0] DATA_OFFSET = DATA_OFFSET_DEF,
    parameter int          DMEM_BYTES  = 32,
    parameter logic [31:0] LED_ADDR    = 32'd2003,
    parameter int          LED_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    krv_dmem_io_if.slave         bus,
    output logic [LED_WIDTH-1:0] leds
);
    localparam int            AW      = $clog2(DMEM_BYTES);
    localparam logic [AW-1:0] LED_IDX = AW'(LED_ADDR - DATA_OFFSET);

    state_e        state_q, state_d;
    logic          we_q, we_d, sgn_q, sgn_d, err_q, err_d, rdy_en_q;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] ofs_q, ofs_d;
    logic [2:0]    cnt_q, cnt_d, nb_q, nb_d;
    logic [31:0]   wdata_q, wdata_d, acc_q, acc_d;
    logic [7:0]    mem_q [DMEM_BYTES];
    logic [7:0]    mem_d [DMEM_BYTES];

    logic [AW-1:0] chk_ofs, idx;
    logic [2:0]    chk_nb;
    logic          chk_err, cnt_hit, skip_mem;
    logic [1:0]    bsel;
    logic [7:0]    wbyte;

    krv_addr_check #(.DATA_OFFSET(DATA_OFFSET), .DMEM_BYTES(DMEM_BYTES)) u_addr_check (
        .addr(bus.req_addr), .size(bus.req_size),
        .offset(chk_ofs), .nbytes(chk_nb), .err(chk_err)
    );

    // Stores go MSB first: byte nbytes-1-cnt of the right-aligned data.
    assign idx   = ofs_q + AW'(cnt_q);
    assign bsel  = 2'(nb_q - 3'd1 - cnt_q);
    assign wbyte = 8'(wdata_q >> {bsel, 3'b000});
    assign leds  = ~mem_q[LED_IDX][LED_WIDTH-1:0];

`ifdef KRV_CYCLE_CNT_EN
    logic        cnt_acc_q, cnt_acc_d;
    logic [31:0] cyc_q;

    assign cnt_hit  = (bus.req_addr == DATA_OFFSET + 32'(DMEM_BYTES)) && (bus.req_size == SZ_WORD);
    assign skip_mem = cnt_acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q     <= '0;
            cnt_acc_q <= 1'b0;
        end else begin
            cyc_q     <= cyc_q + 32'd1;
            cnt_acc_q <= cnt_acc_d;
        end
    end
`else
    assign cnt_hit  = 1'b0;
    assign skip_mem = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        ofs_d   = ofs_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        acc_d   = acc_q;
        err_d   = err_q;
        mem_d   = mem_q;
`ifdef KRV_CYCLE_CNT_EN
        cnt_acc_d = cnt_acc_q;
`endif
        bus.req_ready = (state_q == ST_IDLE) & rdy_en_q;
        bus.rsp_valid = (state_q == ST_RESP);

        case (state_q)
            ST_IDLE: if (bus.req_valid && bus.req_ready) begin
                we_d    = bus.req_we;
                size_d  = bus.req_size;
                sgn_d   = bus.req_signed;
                ofs_d   = chk_ofs;
                wdata_d = bus.req_wdata;
                cnt_d   = 3'd0;
                nb_d    = chk_nb;
                acc_d   = '0;
                err_d   = chk_err;
                // Counter reads still walk four XFER cycles to keep word latency.
                if (cnt_hit) begin
                    err_d = 1'b0;
                    nb_d  = 3'd4;
`ifdef KRV_CYCLE_CNT_EN
                    acc_d = cyc_q;
`endif
                end
`ifdef KRV_CYCLE_CNT_EN
                cnt_acc_d = cnt_hit;
`endif
                state_d = err_d ? ST_RESP : ST_XFER;
            end
            ST_XFER: begin
                if (!skip_mem) begin
                    if (we_q) mem_d[idx] = wbyte;
                    else      acc_d = {acc_q[23:0], mem_q[idx]};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == nb_q - 3'd1) state_d = ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.rsp_err   = err_q;
        bus.rsp_rdata = '0;
        if (state_q == ST_RESP && !we_q && !err_q) begin
            case (size_q)
                SZ_BYTE: bus.rsp_rdata = {{24{sgn_q & acc_q[7]}}, acc_q[7:0]};
                SZ_HALF: bus.rsp_rdata = {{16{sgn_q & acc_q[15]}}, acc_q[15:0]};
                default: bus.rsp_rdata = acc_q;
            endcase
        end
    end

    // rdy_en_q holds req_ready low through reset and the first cycle after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            sgn_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            ofs_q    <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            nb_q     <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
            for (int i = 0; i < DMEM_BYTES; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            sgn_q    <= sgn_d;
            size_q   <= size_d;
            ofs_q    <= ofs_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            nb_q     <= nb_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_krv_dmem_io.sv
// Scoreboard bench for krv_dmem_io: directed loads/stores push expected
// responses; a negedge monitor pops and checks data, error and latency.
module tb_krv_dmem_io;
    import krv_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] leds;

    krv_dmem_io_if bus();
    krv_dmem_io dut (.clk(clk), .rst(rst), .bus(bus), .leds(leds));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, rel = 0, rise = 0, nvec = 0, nerr = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid && !prev_v) rise = cyc;
        prev_v = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_rsp: rdata %h err %b with empty scoreboard", bus.rsp_rdata, bus.rsp_err);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(rise - e.acc), 32'(e.lat));
            end
        end
    end

    // Present a request, wait (bounded) for acceptance and push its expectation.
    // Returns at the negedge of cycle 1 (the cycle after accept).
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input logic use_cnt);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: addr %0d never accepted", a);
            bus.req_valid = 1'b0;
            return;
        end
        e.rdata = use_cnt ? 32'(cyc - rel) : er;
        e.err   = ee;
        e.lat   = ee ? 1 : (sz == SZ_WORD ? 5 : (sz == SZ_HALF ? 3 : 2));
        e.acc   = cyc;
        q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL rsp_timeout: %0d responses outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic tr(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
        issue(we, sz, sg, a, wd, er, ee, 1'b0);
        drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_leds"}, 32'(leds), 32'h3F);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b1; rel = cyc;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        tr(0, SZ_WORD, 0, 2000, 0, 32'h0, 0);
        tr(1, SZ_WORD, 0, 2000, 32'h12345678, 32'h0, 0);
        tr(0, SZ_BYTE, 1, 2000, 0, 32'h12, 0);
        tr(0, SZ_BYTE, 0, 2003, 0, 32'h78, 0);
        tr(0, SZ_HALF, 0, 2002, 0, 32'h5678, 0);
        tr(0, SZ_WORD, 0, 2000, 0, 32'h12345678, 0);
        chk("leds_78", 32'(leds), 32'h07);

        // LED byte write lands at the end of cycle 1, visible in cycle 2.
        issue(1, SZ_BYTE, 0, 2003, 32'hA5, 32'h0, 0, 0);
        chk("leds_before_write", 32'(leds), 32'h07);
        @(negedge clk);
        chk("leds_after_write", 32'(leds), 32'h1A);
        drain();
        tr(0, SZ_BYTE, 1, 2003, 0, 32'hFFFFFFA5, 0);
        tr(0, SZ_BYTE, 0, 2003, 0, 32'hA5, 0);
        tr(1, SZ_HALF, 0, 2000, 32'h8001, 32'h0, 0);
        tr(0, SZ_HALF, 1, 2000, 0, 32'hFFFF8001, 0);
        tr(0, SZ_WORD, 0, 2000, 0, 32'h800156A5, 0);

        tr(1, SZ_WORD, 0, 2028, 32'hCAFEF00D, 32'h0, 0);
        tr(0, SZ_BYTE, 0, 2031, 0, 32'h0D, 0);
        tr(0, SZ_HALF, 1, 2028, 0, 32'hFFFFCAFE, 0);

        tr(1, SZ_WORD, 0, 2002, 32'hFFFFFFFF, 32'h0, 1);
        tr(0, SZ_HALF, 0, 2001, 0, 32'h0, 1);
`ifndef KRV_CYCLE_CNT_EN
        tr(0, SZ_WORD, 0, 2032, 0, 32'h0, 1);
`endif
        tr(0, SZ_WORD, 0, 1996, 0, 32'h0, 1);
        tr(0, SZ_ILL, 0, 2000, 0, 32'h0, 1);
        tr(0, SZ_BYTE, 0, 2032, 0, 32'h0, 1);
        tr(1, SZ_HALF, 0, 2031, 32'hFFFF, 32'h0, 1);
        tr(1, SZ_BYTE, 0, 32'h0, 32'hFF, 32'h0, 1);
        tr(0, SZ_WORD, 0, 2000, 0, 32'h800156A5, 0);
        tr(0, SZ_WORD, 0, 2028, 0, 32'hCAFEF00D, 0);

        bus.rsp_ready = 1'b0;
        issue(0, SZ_WORD, 0, 2000, 0, 32'h800156A5, 0, 0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h800156A5);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        drain();

        // Reset lands in the second XFER cycle of a word store.
        issue(1, SZ_WORD, 0, 2004, 32'hDEADBEEF, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1; rel = cyc;
        @(negedge clk);
        chk("ready_after_rst_mid", 32'(bus.req_ready), 32'd1);
        tr(0, SZ_WORD, 0, 2004, 0, 32'h0, 0);
        tr(0, SZ_WORD, 0, 2000, 0, 32'h0, 0);

`ifdef KRV_CYCLE_CNT_EN
        issue(0, SZ_WORD, 0, 2032, 0, 32'h0, 0, 1);
        drain();
        repeat (3) @(negedge clk);
        issue(0, SZ_WORD, 0, 2032, 0, 32'h0, 0, 1);
        drain();
        tr(1, SZ_WORD, 0, 2032, 32'h55AA55AA, 32'h0, 0);
        tr(0, SZ_HALF, 0, 2032, 0, 32'h0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
